// File: rtl/if_fetch_queue_if.sv
`default_nettype none
// ============================================================================
// Module      : if_fetch_queue_if
// Description : Fetch-side buses: instruction-memory port, redirect input and
//               the decode valid/ready handshake.
// Revision    : 1.0
// ============================================================================
interface if_fetch_queue_if;
  logic [31:0] im_pc;
  logic [31:0] im_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        if_fault;

  modport master (
    output im_pc,
    input  im_instr,
    input  redirect_valid,
    input  redirect_pc,
    output if_valid,
    input  if_ready,
    output if_pc,
    output if_instr,
    output if_fault
  );

  modport slave (
    input  im_pc,
    output im_instr,
    output redirect_valid,
    output redirect_pc,
    input  if_valid,
    output if_ready,
    input  if_pc,
    input  if_instr,
    input  if_fault
  );
endinterface
`default_nettype wire

// File: rtl/if_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : if_fetch_queue
// Description : PC owner and instruction-fetch FIFO feeding decode, with
//               stall backpressure and redirect flush/refetch.
// Revision    : 1.0
// ============================================================================
module if_fetch_queue #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2,
  parameter int unsigned IM_WORDS = 256
) (
  input  logic           clk,
  input  logic           rst_n,
  if_fetch_queue_if.master bus
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] c_full_count = (AW+1)'(DEPTH);

  logic [31:0]   r_pc;
  logic [AW:0]   r_count;
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [31:0]   r_ent_pc    [DEPTH];
  logic [31:0]   r_ent_instr [DEPTH];
  logic          r_ent_fault [DEPTH];

  logic w_deq;
  logic w_fetch;
  logic w_fault;

  assign w_deq   = bus.if_valid & bus.if_ready;
  assign w_fetch = ~bus.redirect_valid & ((r_count != c_full_count) | w_deq);
  assign w_fault = {2'b00, r_pc[31:2]} >= IM_WORDS;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc        <= RESET_PC;
      r_count     <= '0;
      r_rd_ptr    <= '0;
      r_wr_ptr    <= '0;
      r_ent_pc    <= '{default: '0};
      r_ent_instr <= '{default: '0};
      r_ent_fault <= '{default: 1'b0};
    end else if (bus.redirect_valid) begin
      // Flush wins over any same-cycle fetch; a same-cycle deq was already seen by decode.
      r_pc     <= {bus.redirect_pc[31:2], 2'b00};
      r_count  <= '0;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
    end else begin
      if (w_fetch) begin
        r_ent_pc[r_wr_ptr]    <= r_pc;
        r_ent_instr[r_wr_ptr] <= w_fault ? 32'h0 : bus.im_instr;
        r_ent_fault[r_wr_ptr] <= w_fault;
        r_wr_ptr              <= r_wr_ptr + 1'b1;
        r_pc                  <= r_pc + 32'd4;
      end
      if (w_deq) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_fetch, w_deq})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign bus.im_pc    = r_pc;
  assign bus.if_valid = (r_count != '0);
  assign bus.if_pc    = r_ent_pc[r_rd_ptr];
  assign bus.if_instr = r_ent_instr[r_rd_ptr];
  assign bus.if_fault = r_ent_fault[r_rd_ptr];

endmodule
`default_nettype wire
